// File: rtl/rst_seq_gen_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Counter width large enough to hold the largest of the three cycle limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Control/status bundle between the reset sequencer and its consumer.
interface rst_seq_gen_if #(
  parameter int NUM_CH = 4
);
  localparam int SW = $clog2(NUM_CH + 1);

  logic              lock_in;
  logic              soft_rst_req;
  logic [NUM_CH-1:0] rst_out;
  logic              rst_done;
  logic [SW-1:0]     stage;

  modport master (
    output lock_in, soft_rst_req,
    input  rst_out, rst_done, stage
  );

  modport slave (
    input  lock_in, soft_rst_req,
    output rst_out, rst_done, stage
  );
endinterface

// File: rtl/rst_seq_gen_lock_filt.sv
// Lock qualifier: o_lock_stable fires on the cycle lock_in completes LOCK_FILT consecutive highs.
module rst_seq_gen_lock_filt #(
  parameter int LOCK_FILT = 8,
  parameter int CW        = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_lock,
  output logic o_lock_stable
);
  localparam logic [CW-1:0] LAST = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] FULL = CW'(LOCK_FILT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_lock) begin
      r_cnt <= '0;
    end else if (r_cnt != FULL) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Count reaches LOCK_FILT on this edge.
  assign o_lock_stable = i_lock && (r_cnt >= LAST);
endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds all channels until lock is stable, then releases them in index order.
module rst_seq_gen
  import rst_seq_gen_pkg::*;
#(
  parameter int              NUM_CH    = 4,
  parameter logic [NUM_CH-1:0] RST_LEVEL = '0,
  parameter int              LOCK_FILT = 8,
  parameter int              HOLD_CYC  = 200,
  parameter int              STAGE_GAP = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  rst_seq_gen_if.slave bus
);
  localparam int CW = cnt_width(LOCK_FILT, HOLD_CYC, STAGE_GAP);
  localparam int SW = $clog2(NUM_CH + 1);
  localparam logic [CW-1:0] TMR_SAT   = CW'((HOLD_CYC > STAGE_GAP) ? HOLD_CYC : STAGE_GAP);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] LAST_CH   = SW'(NUM_CH - 1);

  if (NUM_CH < 1 || LOCK_FILT < 1 || HOLD_CYC < 1 || STAGE_GAP < 1) begin : g_param_err
    $error("rst_seq_gen: NUM_CH, LOCK_FILT, HOLD_CYC and STAGE_GAP must all be >= 1");
  end

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_tmr, w_tmr_nxt;
  logic [NUM_CH-1:0] r_rst_out, w_rst_out_nxt;
  logic              r_done, w_done_nxt;
  logic [SW-1:0]     r_stage, w_stage_nxt;
  logic              w_lock_stable, w_filt_clr, w_abort;
  logic              w_hold_last, w_gap_last, w_last_ch;

  assign w_abort     = (r_state != WAIT_LOCK) && (!bus.lock_in || bus.soft_rst_req);
  assign w_hold_last = (r_state == HOLD) && (r_tmr == HOLD_LAST);
  assign w_gap_last  = (r_state == RELEASE) && (r_tmr == GAP_LAST);
  assign w_last_ch   = (r_stage == LAST_CH);
  assign w_filt_clr  = (r_state != WAIT_LOCK) || bus.soft_rst_req || w_lock_stable;

  rst_seq_gen_lock_filt #(.LOCK_FILT(LOCK_FILT), .CW(CW)) u_lock_filt (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (w_filt_clr),
    .i_lock        (bus.lock_in),
    .o_lock_stable (w_lock_stable)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= WAIT_LOCK;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = WAIT_LOCK;
    end else begin
      case (r_state)
        WAIT_LOCK: if (w_lock_stable && !bus.soft_rst_req) w_state_nxt = HOLD;
        HOLD:      if (w_hold_last) w_state_nxt = (NUM_CH == 1) ? DONE : RELEASE;
        RELEASE:   if (w_gap_last && w_last_ch) w_state_nxt = DONE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_rst_out_nxt = r_rst_out;
    w_done_nxt    = r_done;
    w_stage_nxt   = r_stage;
    w_tmr_nxt     = (r_tmr != TMR_SAT) ? r_tmr + 1'b1 : r_tmr;
    if (w_abort) begin
      w_rst_out_nxt = RST_LEVEL;
      w_done_nxt    = 1'b0;
      w_stage_nxt   = '0;
      w_tmr_nxt     = '0;
    end else begin
      case (r_state)
        HOLD: if (w_hold_last) begin
          w_rst_out_nxt[0] = ~RST_LEVEL[0];
          w_stage_nxt      = SW'(1);
          w_done_nxt       = (NUM_CH == 1);
          w_tmr_nxt        = '0;
        end
        RELEASE: if (w_gap_last) begin
          // Channel index equals the count already released.
          for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(r_stage)) w_rst_out_nxt[i] = ~RST_LEVEL[i];
          end
          w_stage_nxt = r_stage + 1'b1;
          w_done_nxt  = w_last_ch;
          w_tmr_nxt   = '0;
        end
        default: w_tmr_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmr     <= '0;
      r_rst_out <= RST_LEVEL;
      r_done    <= 1'b0;
      r_stage   <= '0;
    end else begin
      r_tmr     <= w_tmr_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_done    <= w_done_nxt;
      r_stage   <= w_stage_nxt;
    end
  end

  assign bus.rst_out  = r_rst_out;
  assign bus.rst_done = r_done;
  assign bus.stage    = r_stage;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: 4-channel instance plus a 1-channel corner instance.
module tb_rst_seq_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rst_seq_gen_if #(.NUM_CH(4)) bus0 ();
  rst_seq_gen_if #(.NUM_CH(1)) bus1 ();

  rst_seq_gen #(
    .NUM_CH(4), .RST_LEVEL(4'b0101), .LOCK_FILT(4), .HOLD_CYC(20), .STAGE_GAP(5)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus0)
  );

  rst_seq_gen #(
    .NUM_CH(1), .RST_LEVEL(1'b1), .LOCK_FILT(1), .HOLD_CYC(1), .STAGE_GAP(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );

  typedef struct {
    int         scn;
    int         edge_n;
    logic [3:0] rst_out;
    logic       done;
    logic [2:0] stage;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  // edge numbers at which inputs are sampled: lock low in [lo,hi], soft pulse, rst pulse
  int   lo, hi, soft_e, rst_e;

  task automatic check(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
    end
  endtask

  task automatic check0(input int e, input logic [3:0] r, input logic d, input logic [2:0] s);
    check("rst_out", e, 32'(bus0.rst_out), 32'(r));
    check("rst_done", e, 32'(bus0.rst_done), 32'(d));
    check("stage", e, 32'(bus0.stage), 32'(s));
  endtask

  task automatic check1(input int e, input logic r, input logic d, input logic s);
    check("ch1_rst_out", e, 32'(bus1.rst_out), 32'(r));
    check("ch1_rst_done", e, 32'(bus1.rst_done), 32'(d));
    check("ch1_stage", e, 32'(bus1.stage), 32'(s));
  endtask

  task automatic set_cfg(input int s);
    lo = -1; hi = -1; soft_e = -1; rst_e = -1;
    case (s)
      1: begin lo = 1; hi = 100000; end
      3: begin lo = 4; hi = 4; end
      4: begin lo = 31; hi = 31; end
      5: soft_e = 51;
      6: rst_e = 33;
      7: soft_e = 4;
      default: ;
    endcase
  endtask

  task automatic drive(input logic r, input logic lk, input logic sf);
    rst               = r;
    bus0.lock_in      = lk;
    bus1.lock_in      = lk;
    bus0.soft_rst_req = sf;
    bus1.soft_rst_req = sf;
  endtask

  // Inputs are set between edges so they are sampled by edge edge_n+1.
  task automatic step();
    int nx;
    nx = edge_n + 1;
    drive(nx == rst_e, !(nx >= lo && nx <= hi), nx == soft_e);
    @(posedge clk);
    #1;
    edge_n = nx;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    edge_n = 0;
    check0(0, 4'b0101, 1'b0, 3'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // scenario 1: no lock
    vecs.push_back('{1, 1,   4'b0101, 1'b0, 3'd0});
    vecs.push_back('{1, 50,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{1, 100, 4'b0101, 1'b0, 3'd0});
    // scenario 2: clean lock
    vecs.push_back('{2, 23,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{2, 24,  4'b0100, 1'b0, 3'd1});
    vecs.push_back('{2, 28,  4'b0100, 1'b0, 3'd1});
    vecs.push_back('{2, 29,  4'b0110, 1'b0, 3'd2});
    vecs.push_back('{2, 34,  4'b0010, 1'b0, 3'd3});
    vecs.push_back('{2, 38,  4'b0010, 1'b0, 3'd3});
    vecs.push_back('{2, 39,  4'b1010, 1'b1, 3'd4});
    vecs.push_back('{2, 60,  4'b1010, 1'b1, 3'd4});
    // scenario 3: lock glitch during filtering
    vecs.push_back('{3, 27,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{3, 28,  4'b0100, 1'b0, 3'd1});
    vecs.push_back('{3, 42,  4'b0010, 1'b0, 3'd3});
    vecs.push_back('{3, 43,  4'b1010, 1'b1, 3'd4});
    // scenario 4: lock loss mid-release
    vecs.push_back('{4, 30,  4'b0110, 1'b0, 3'd2});
    vecs.push_back('{4, 31,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{4, 54,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{4, 55,  4'b0100, 1'b0, 3'd1});
    // scenario 5: soft reset from DONE
    vecs.push_back('{5, 50,  4'b1010, 1'b1, 3'd4});
    vecs.push_back('{5, 51,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{5, 74,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{5, 75,  4'b0100, 1'b0, 3'd1});
    vecs.push_back('{5, 89,  4'b0010, 1'b0, 3'd3});
    vecs.push_back('{5, 90,  4'b1010, 1'b1, 3'd4});
    // scenario 6: rst during RELEASE, sequence re-runs from edge 34 as new edge 1
    vecs.push_back('{6, 32,  4'b0110, 1'b0, 3'd2});
    vecs.push_back('{6, 33,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{6, 56,  4'b0101, 1'b0, 3'd0});
    vecs.push_back('{6, 57,  4'b0100, 1'b0, 3'd1});
    vecs.push_back('{6, 72,  4'b1010, 1'b1, 3'd4});

    for (int s = 1; s <= 6; s++) begin
      set_cfg(s);
      do_reset();
      foreach (vecs[i]) begin
        if (vecs[i].scn == s) begin
          while (edge_n < vecs[i].edge_n) step();
          check0(edge_n, vecs[i].rst_out, vecs[i].done, vecs[i].stage);
        end
      end
    end

    // NUM_CH=1 corner plus soft request while the 4-channel filter is about to fire
    set_cfg(7);
    do_reset();
    check1(0, 1'b1, 1'b0, 1'b0);
    step();
    check1(edge_n, 1'b1, 1'b0, 1'b0);
    step();
    check1(edge_n, 1'b0, 1'b1, 1'b1);
    step();
    check1(edge_n, 1'b0, 1'b1, 1'b1);
    step();
    check1(edge_n, 1'b1, 1'b0, 1'b0);
    check0(edge_n, 4'b0101, 1'b0, 3'd0);
    step();
    check1(edge_n, 1'b1, 1'b0, 1'b0);
    step();
    check1(edge_n, 1'b0, 1'b1, 1'b1);
    while (edge_n < 27) step();
    check0(edge_n, 4'b0101, 1'b0, 3'd0);
    step();
    check0(edge_n, 4'b0100, 1'b0, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
